// File: rtl/eg_video_pkg.sv
`default_nettype none
// ============================================================================
// Module      : eg_video_pkg
// Description : Shared types and constants for the colour-output stage:
//               default Colour Genie palette, host register map and the
//               R/G/B triplet phase type.
// Revision    : 1.0 - initial release
// ============================================================================
package eg_video_pkg;

  // Position inside an R, G, B triplet sequence
  typedef enum logic [1:0] {
    PH_R = 2'd0,
    PH_G = 2'd1,
    PH_B = 2'd2
  } phase_e;

  // Host register map
  localparam logic [1:0] c_ADDR_WR_IDX = 2'd0;
  localparam logic [1:0] c_ADDR_DATA   = 2'd1;
  localparam logic [1:0] c_ADDR_RD_IDX = 2'd2;
  localparam logic [1:0] c_ADDR_MASK   = 2'd3;

  // Default Colour Genie palette, 8 bits per channel, packed {R,G,B}
  localparam logic [23:0] c_CG_PALETTE [16] = '{
    24'h5E564F, 24'h0F39FF, 24'hC9245D, 24'hC842EE,
    24'h599941, 24'h3AF0EB, 24'hDFFE73, 24'hFFFFFF,
    24'h8A888C, 24'h2A5BFF, 24'hFF4080, 24'hFF5FFF,
    24'h7FFF7F, 24'h5FFFFF, 24'hFFFF9F, 24'h404040
  };

  // One default channel (sel 0=R, 1=G, 2=B) truncated to its ch_bits MSBs,
  // right-aligned; indices outside the 16-entry table give black.
  function automatic logic [7:0] f_default_chan(input int idx, input int ch_bits,
                                                input int sel);
    logic [23:0] ent;
    logic [7:0]  chan;
    if (idx < 0 || idx > 15) begin
      return 8'h00;
    end
    ent = c_CG_PALETTE[idx[3:0]];
    case (sel)
      0:       chan = ent[23:16];
      1:       chan = ent[15:8];
      default: chan = ent[7:0];
    endcase
    return chan >> (8 - ch_bits);
  endfunction

endpackage
`default_nettype wire

// File: rtl/eg_palette_ram.sv
`default_nettype none
// ============================================================================
// Module      : eg_palette_ram
// Description : Palette storage, 2^IDX_BITS x 3*CH_BITS. One synchronous
//               write port, one asynchronous pixel read port and, when
//               EG_PALETTE_READBACK_EN is defined, an asynchronous host read
//               port. Contents load from the package default palette at
//               configuration and are never reset.
// Revision    : 1.0 - initial release
// ============================================================================
module eg_palette_ram
  import eg_video_pkg::*;
#(
  parameter int IDX_BITS = 4,
  parameter int CH_BITS  = 6
) (
  input  logic                   clk,
  input  logic                   i_we,
  input  logic [IDX_BITS-1:0]    i_waddr,
  input  logic [3*CH_BITS-1:0]   i_wdata,
  input  logic [IDX_BITS-1:0]    i_pix_addr,
  output logic [3*CH_BITS-1:0]   o_pix_data
`ifdef EG_PALETTE_READBACK_EN
  ,
  input  logic [IDX_BITS-1:0]    i_host_addr,
  output logic [3*CH_BITS-1:0]   o_host_data
`endif
);

  localparam int c_DEPTH = 2 ** IDX_BITS;
  localparam int c_RGB_W = 3 * CH_BITS;

  function automatic logic [c_DEPTH-1:0][c_RGB_W-1:0] f_init_mem();
    logic [c_DEPTH-1:0][c_RGB_W-1:0] mem;
    for (int i = 0; i < c_DEPTH; i++) begin
      mem[IDX_BITS'(i)] = {CH_BITS'(f_default_chan(i, CH_BITS, 0)),
                           CH_BITS'(f_default_chan(i, CH_BITS, 1)),
                           CH_BITS'(f_default_chan(i, CH_BITS, 2))};
    end
    return mem;
  endfunction

  logic [c_DEPTH-1:0][c_RGB_W-1:0] r_mem = f_init_mem();

  // Commit a full triplet; reads of the same entry this cycle see old data
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_pix_data = r_mem[i_pix_addr];

`ifdef EG_PALETTE_READBACK_EN
  assign o_host_data = r_mem[i_host_addr];
`endif

endmodule
`default_nettype wire

// File: rtl/eg_palette_dac.sv
`default_nettype none
// ============================================================================
// Module      : eg_palette_dac
// Description : Colour-output stage. Host-writable palette with VGA-DAC-style
//               index/triplet write sequencer, pixel mask, and a two-stage
//               ce_pix pipeline keeping syncs aligned with colour.
//               Optional host read-back enabled by EG_PALETTE_READBACK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module eg_palette_dac
  import eg_video_pkg::*;
#(
  parameter int IDX_BITS = 4,
  parameter int CH_BITS  = 6
) (
  input  logic                clock,
  input  logic                power,
  input  logic                ce_pix,
  input  logic                pixel,
  input  logic [IDX_BITS-1:0] color,
  input  logic                hsync_in,
  input  logic                vsync_in,
  input  logic                io_cs,
  input  logic                io_wr,
  input  logic                io_rd,
  input  logic [1:0]          io_a,
  input  logic [7:0]          io_di,
  output logic [7:0]          io_do,
  output logic [CH_BITS-1:0]  r,
  output logic [CH_BITS-1:0]  g,
  output logic [CH_BITS-1:0]  b,
  output logic                hsync,
  output logic                vsync
);

  localparam int c_RGB_W = 3 * CH_BITS;

  // Host strobes; accesses during reset are dropped so RAM stays untouched
  logic w_wr_acc;
  logic w_rd_acc;
  assign w_wr_acc = io_cs & io_wr & power;
  assign w_rd_acc = io_cs & io_rd & ~io_wr & power;

  // Write sequencer state
  logic [IDX_BITS-1:0] r_wr_idx, w_wr_idx_nxt;
  phase_e              r_wr_ph, w_wr_ph_nxt;
  logic [CH_BITS-1:0]  r_hold_r, r_hold_g;
  logic [IDX_BITS-1:0] r_mask;
  logic                w_commit;

  // Pixel pipeline state
  logic [IDX_BITS-1:0] r_s1_idx;
  logic                r_s1_pix, r_s1_hs, r_s1_vs;
  logic [c_RGB_W-1:0]  r_rgb;
  logic                r_hs, r_vs;
  logic [c_RGB_W-1:0]  w_pix_data;

  // Host read data
  logic [7:0] r_io_do, w_do_nxt;
  logic [7:0] w_rb_data, w_rb_idx;

  // Next-state for the write index/phase; the B write commits the triplet
  always_comb begin
    w_wr_idx_nxt = r_wr_idx;
    w_wr_ph_nxt  = r_wr_ph;
    w_commit     = 1'b0;
    if (w_wr_acc) begin
      case (io_a)
        c_ADDR_WR_IDX: begin
          w_wr_idx_nxt = IDX_BITS'(io_di);
          w_wr_ph_nxt  = PH_R;
        end
        c_ADDR_DATA: begin
          case (r_wr_ph)
            PH_R:    w_wr_ph_nxt = PH_G;
            PH_G:    w_wr_ph_nxt = PH_B;
            default: begin
              w_commit     = 1'b1;
              w_wr_idx_nxt = r_wr_idx + IDX_BITS'(1);
              w_wr_ph_nxt  = PH_R;
            end
          endcase
        end
        default: ;
      endcase
    end
  end

  // Write sequencer and mask registers
  always_ff @(posedge clock) begin
    if (!power) begin
      r_wr_idx <= '0;
      r_wr_ph  <= PH_R;
      r_mask   <= '1;
    end else begin
      r_wr_idx <= w_wr_idx_nxt;
      r_wr_ph  <= w_wr_ph_nxt;
      if (w_wr_acc && io_a == c_ADDR_MASK) begin
        r_mask <= IDX_BITS'(io_di);
      end
    end
  end

  // R and G holding registers; a phase reset makes stale values irrelevant
  always_ff @(posedge clock) begin
    if (w_wr_acc && io_a == c_ADDR_DATA) begin
      if (r_wr_ph == PH_R) begin
        r_hold_r <= CH_BITS'(io_di);
      end
      if (r_wr_ph == PH_G) begin
        r_hold_g <= CH_BITS'(io_di);
      end
    end
  end

`ifdef EG_PALETTE_READBACK_EN
  logic [IDX_BITS-1:0] r_rd_idx, w_rd_idx_nxt;
  phase_e              r_rd_ph, w_rd_ph_nxt;
  logic [c_RGB_W-1:0]  w_host_data;
  logic [CH_BITS-1:0]  w_rb_chan;

  // Read-back index/phase next-state and channel select
  always_comb begin
    w_rd_idx_nxt = r_rd_idx;
    w_rd_ph_nxt  = r_rd_ph;
    case (r_rd_ph)
      PH_R:    w_rb_chan = w_host_data[2*CH_BITS +: CH_BITS];
      PH_G:    w_rb_chan = w_host_data[CH_BITS +: CH_BITS];
      default: w_rb_chan = w_host_data[0 +: CH_BITS];
    endcase
    if (w_wr_acc && io_a == c_ADDR_RD_IDX) begin
      w_rd_idx_nxt = IDX_BITS'(io_di);
      w_rd_ph_nxt  = PH_R;
    end else if (w_rd_acc && io_a == c_ADDR_DATA) begin
      case (r_rd_ph)
        PH_R:    w_rd_ph_nxt = PH_G;
        PH_G:    w_rd_ph_nxt = PH_B;
        default: begin
          w_rd_idx_nxt = r_rd_idx + IDX_BITS'(1);
          w_rd_ph_nxt  = PH_R;
        end
      endcase
    end
  end

  // Read-back state registers
  always_ff @(posedge clock) begin
    if (!power) begin
      r_rd_idx <= '0;
      r_rd_ph  <= PH_R;
    end else begin
      r_rd_idx <= w_rd_idx_nxt;
      r_rd_ph  <= w_rd_ph_nxt;
    end
  end

  assign w_rb_data = 8'(w_rb_chan);
  assign w_rb_idx  = 8'(r_rd_idx);
`else
  assign w_rb_data = 8'h00;
  assign w_rb_idx  = 8'h00;
`endif

  eg_palette_ram #(
    .IDX_BITS (IDX_BITS),
    .CH_BITS  (CH_BITS)
  ) u_ram (
    .clk         (clock),
    .i_we        (w_commit),
    .i_waddr     (r_wr_idx),
    .i_wdata     ({r_hold_r, r_hold_g, CH_BITS'(io_di)}),
    .i_pix_addr  (r_s1_idx),
    .o_pix_data  (w_pix_data)
`ifdef EG_PALETTE_READBACK_EN
    ,
    .i_host_addr (r_rd_idx),
    .o_host_data (w_host_data)
`endif
  );

  // Two-stage pixel pipeline: masked index, then palette lookup with blanking
  always_ff @(posedge clock) begin
    if (!power) begin
      r_s1_idx <= '0;
      r_s1_pix <= 1'b0;
      r_s1_hs  <= 1'b0;
      r_s1_vs  <= 1'b0;
      r_rgb    <= '0;
      r_hs     <= 1'b0;
      r_vs     <= 1'b0;
    end else if (ce_pix) begin
      r_s1_idx <= color & r_mask;
      r_s1_pix <= pixel;
      r_s1_hs  <= hsync_in;
      r_s1_vs  <= vsync_in;
      r_rgb    <= r_s1_pix ? w_pix_data : '0;
      r_hs     <= r_s1_hs;
      r_vs     <= r_s1_vs;
    end
  end

  // Host read data select; holds unless a read strobe is seen
  always_comb begin
    w_do_nxt = r_io_do;
    if (w_rd_acc) begin
      case (io_a)
        c_ADDR_WR_IDX: w_do_nxt = 8'(r_wr_idx);
        c_ADDR_DATA:   w_do_nxt = w_rb_data;
        c_ADDR_RD_IDX: w_do_nxt = w_rb_idx;
        default:       w_do_nxt = 8'(r_mask);
      endcase
    end
  end

  // Registered host read data
  always_ff @(posedge clock) begin
    if (!power) begin
      r_io_do <= 8'h00;
    end else begin
      r_io_do <= w_do_nxt;
    end
  end

  assign io_do     = r_io_do;
  assign {r, g, b} = r_rgb;
  assign hsync     = r_hs;
  assign vsync     = r_vs;

endmodule
`default_nettype wire

// File: tb/tb_eg_palette_dac.sv
`default_nettype none
// ============================================================================
// Module      : tb_eg_palette_dac
// Description : Self-checking bench for eg_palette_dac (IDX_BITS=4,
//               CH_BITS=6). A behavioural model tracks palette, sequencer and
//               pipeline; directed literal checks pin the model.
//               Read-back expectations follow EG_PALETTE_READBACK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_eg_palette_dac;

  localparam int IDX_BITS = 4;
  localparam int CH_BITS  = 6;

  logic       clock = 1'b0;
  logic       power = 1'b0;
  logic       ce_pix = 1'b0;
  logic       pixel = 1'b0;
  logic [3:0] color = 4'd0;
  logic       hsync_in = 1'b0;
  logic       vsync_in = 1'b0;
  logic       io_cs = 1'b0;
  logic       io_wr = 1'b0;
  logic       io_rd = 1'b0;
  logic [1:0] io_a = 2'd0;
  logic [7:0] io_di = 8'd0;
  logic [7:0] io_do;
  logic [5:0] r, g, b;
  logic       hsync, vsync;

  always #5 clock = ~clock;

  eg_palette_dac #(
    .IDX_BITS (IDX_BITS),
    .CH_BITS  (CH_BITS)
  ) dut (
    .clock    (clock),
    .power    (power),
    .ce_pix   (ce_pix),
    .pixel    (pixel),
    .color    (color),
    .hsync_in (hsync_in),
    .vsync_in (vsync_in),
    .io_cs    (io_cs),
    .io_wr    (io_wr),
    .io_rd    (io_rd),
    .io_a     (io_a),
    .io_di    (io_di),
    .io_do    (io_do),
    .r        (r),
    .g        (g),
    .b        (b),
    .hsync    (hsync),
    .vsync    (vsync)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [23:0] pal8 [16] = '{
    24'h5E564F, 24'h0F39FF, 24'hC9245D, 24'hC842EE,
    24'h599941, 24'h3AF0EB, 24'hDFFE73, 24'hFFFFFF,
    24'h8A888C, 24'h2A5BFF, 24'hFF4080, 24'hFF5FFF,
    24'h7FFF7F, 24'h5FFFFF, 24'hFFFF9F, 24'h404040
  };

  typedef struct {
    int idx;
    bit pix;
    bit hs;
    bit vs;
  } px_t;

  int          m_ram [16][3];
  int          m_hold [3];
  int          m_wr_idx, m_wr_ph, m_mask, m_rd_idx, m_rd_ph;
  px_t         q [$];
  px_t         m_p;
  bit          m_live = 1'b0;
  bit          e_known = 1'b0;
  logic [17:0] e_rgb;
  bit          e_hs, e_vs;
  logic [7:0]  e_do;
  bit          m_rb_en;

  initial begin
`ifdef EG_PALETTE_READBACK_EN
    m_rb_en = 1'b1;
`else
    m_rb_en = 1'b0;
`endif
    for (int i = 0; i < 16; i++) begin
      m_ram[i][0] = int'(pal8[i][23:16]) / 4;
      m_ram[i][1] = int'(pal8[i][15:8]) / 4;
      m_ram[i][2] = int'(pal8[i][7:0]) / 4;
    end
  end

  // Model advances on each rising edge from the inputs present at that edge
  always @(posedge clock) begin
    if (!power) begin
      m_live   = 1'b1;
      q.delete();
      e_known  = 1'b1;
      e_rgb    = '0;
      e_hs     = 1'b0;
      e_vs     = 1'b0;
      e_do     = 8'h00;
      m_wr_idx = 0;
      m_wr_ph  = 0;
      m_mask   = 15;
      m_rd_idx = 0;
      m_rd_ph  = 0;
    end else if (m_live) begin
      if (ce_pix) begin
        if (q.size() > 0) begin
          m_p     = q.pop_front();
          e_known = 1'b1;
          e_hs    = m_p.hs;
          e_vs    = m_p.vs;
          e_rgb   = m_p.pix ? {6'(m_ram[m_p.idx][0]), 6'(m_ram[m_p.idx][1]),
                               6'(m_ram[m_p.idx][2])} : 18'd0;
        end else begin
          e_known = 1'b0;
        end
        m_p.idx = int'(color) & m_mask;
        m_p.pix = pixel;
        m_p.hs  = hsync_in;
        m_p.vs  = vsync_in;
        q.push_back(m_p);
      end
      if (io_cs && io_rd && !io_wr) begin
        case (io_a)
          2'd0: e_do = 8'(m_wr_idx);
          2'd3: e_do = 8'(m_mask);
          2'd2: e_do = m_rb_en ? 8'(m_rd_idx) : 8'h00;
          default: begin
            if (m_rb_en) begin
              e_do = 8'(m_ram[m_rd_idx][m_rd_ph]);
              if (m_rd_ph == 2) begin
                m_rd_ph  = 0;
                m_rd_idx = (m_rd_idx + 1) % 16;
              end else begin
                m_rd_ph++;
              end
            end else begin
              e_do = 8'h00;
            end
          end
        endcase
      end
      if (io_cs && io_wr) begin
        case (io_a)
          2'd0: begin
            m_wr_idx = int'(io_di) % 16;
            m_wr_ph  = 0;
          end
          2'd1: begin
            m_hold[m_wr_ph] = int'(io_di) % 64;
            if (m_wr_ph == 2) begin
              for (int c = 0; c < 3; c++) m_ram[m_wr_idx][c] = m_hold[c];
              m_wr_idx = (m_wr_idx + 1) % 16;
              m_wr_ph  = 0;
            end else begin
              m_wr_ph++;
            end
          end
          2'd2: begin
            if (m_rb_en) begin
              m_rd_idx = int'(io_di) % 16;
              m_rd_ph  = 0;
            end
          end
          default: m_mask = int'(io_di) % 16;
        endcase
      end
    end
  end

  // Compare DUT against the model on every falling edge
  always @(negedge clock) begin
    if (m_live) begin
      if (e_known) begin
        check("model_rgb", 32'({r, g, b}), 32'(e_rgb));
        check("model_hsync", 32'(hsync), 32'(e_hs));
        check("model_vsync", 32'(vsync), 32'(e_vs));
      end
      check("model_io_do", 32'(io_do), 32'(e_do));
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic host_wr(input logic [1:0] a, input logic [7:0] d);
    io_cs = 1'b1; io_wr = 1'b1; io_rd = 1'b0; io_a = a; io_di = d;
    @(negedge clock);
    io_cs = 1'b0; io_wr = 1'b0;
  endtask

  task automatic host_rd(input logic [1:0] a);
    io_cs = 1'b1; io_rd = 1'b1; io_wr = 1'b0; io_a = a;
    @(negedge clock);
    io_cs = 1'b0; io_rd = 1'b0;
  endtask

  task automatic show(input logic [3:0] idx);
    color = idx; pixel = 1'b1; ce_pix = 1'b1;
    cyc(3);
  endtask

  initial begin
    cyc(3);
    check("reset_rgb", 32'({r, g, b}), 32'd0);
    check("reset_io_do", 32'(io_do), 32'd0);
    check("reset_syncs", 32'({hsync, vsync}), 32'd0);

    // Default palette entry through the two-stage pipeline
    power = 1'b1; color = 4'd2; pixel = 1'b1; ce_pix = 1'b1;
    hsync_in = 1'b1; vsync_in = 1'b0;
    cyc(2);
    check("default_entry2", 32'({r, g, b}), 32'({6'h32, 6'h09, 6'h17}));
    check("default_hsync", 32'({hsync, vsync}), 32'b10);
    pixel = 1'b0; hsync_in = 1'b0; vsync_in = 1'b1;
    cyc(1);
    check("latency_hold", 32'({r, g, b}), 32'({6'h32, 6'h09, 6'h17}));
    cyc(1);
    check("blank_rgb", 32'({r, g, b}), 32'd0);
    check("blank_syncs", 32'({hsync, vsync}), 32'b01);
    vsync_in = 1'b0;

    // Write with auto-increment and wrap
    host_wr(2'd0, 8'd15);
    host_wr(2'd1, 8'h3F); host_wr(2'd1, 8'h00); host_wr(2'd1, 8'h3F);
    host_wr(2'd1, 8'h01); host_wr(2'd1, 8'h02); host_wr(2'd1, 8'h03);
    show(4'd15);
    check("entry15", 32'({r, g, b}), 32'({6'h3F, 6'h00, 6'h3F}));
    show(4'd0);
    check("entry0_wrap", 32'({r, g, b}), 32'({6'h01, 6'h02, 6'h03}));
    host_rd(2'd0);
    check("wr_idx_after_wrap", 32'(io_do), 32'd1);

    // Mid-triplet abort by index write
    host_wr(2'd0, 8'd5); host_wr(2'd1, 8'h10); host_wr(2'd1, 8'h11);
    host_wr(2'd0, 8'd6);
    host_wr(2'd1, 8'h20); host_wr(2'd1, 8'h21); host_wr(2'd1, 8'h22);
    show(4'd5);
    check("entry5_kept", 32'({r, g, b}), 32'({6'h0E, 6'h3C, 6'h3A}));
    show(4'd6);
    check("entry6", 32'({r, g, b}), 32'({6'h20, 6'h21, 6'h22}));

    // Mid-triplet abort by reset
    host_wr(2'd0, 8'd5); host_wr(2'd1, 8'h10); host_wr(2'd1, 8'h11);
    power = 1'b0;
    cyc(2);
    power = 1'b1;
    host_rd(2'd0);
    check("wr_idx_after_reset", 32'(io_do), 32'd0);
    show(4'd5);
    check("entry5_after_reset", 32'({r, g, b}), 32'({6'h0E, 6'h3C, 6'h3A}));
    host_wr(2'd1, 8'h30); host_wr(2'd1, 8'h31); host_wr(2'd1, 8'h32);
    show(4'd0);
    check("entry0_phase_r", 32'({r, g, b}), 32'({6'h30, 6'h31, 6'h32}));
    host_wr(2'd0, 8'hF7);
    host_rd(2'd0);
    check("wr_idx_upper_ignored", 32'(io_do), 32'd7);

    // Pixel mask, and write+read together counting only as a write
    host_wr(2'd3, 8'h03);
    host_rd(2'd3);
    check("mask_read", 32'(io_do), 32'd3);
    show(4'd14);
    check("mask_entry2", 32'({r, g, b}), 32'({6'h32, 6'h09, 6'h17}));
    io_cs = 1'b1; io_wr = 1'b1; io_rd = 1'b1; io_a = 2'd3; io_di = 8'hFF;
    cyc(1);
    io_cs = 1'b0; io_wr = 1'b0; io_rd = 1'b0;
    check("wr_rd_do_holds", 32'(io_do), 32'd3);
    show(4'd14);
    check("mask_restored_e14", 32'({r, g, b}), 32'({6'h3F, 6'h3F, 6'h27}));

    // Collision: commit and pixel read of entry 4 on the same edge
    show(4'd4);
    check("entry4_default", 32'({r, g, b}), 32'({6'h16, 6'h26, 6'h10}));
    host_wr(2'd0, 8'd4); host_wr(2'd1, 8'h0A); host_wr(2'd1, 8'h0B);
    host_wr(2'd1, 8'h0C);
    check("collision_old", 32'({r, g, b}), 32'({6'h16, 6'h26, 6'h10}));
    cyc(1);
    check("collision_new", 32'({r, g, b}), 32'({6'h0A, 6'h0B, 6'h0C}));

    // Outputs hold while ce_pix is low
    ce_pix = 1'b0; color = 4'd2;
    cyc(3);
    check("hold_no_ce", 32'({r, g, b}), 32'({6'h0A, 6'h0B, 6'h0C}));
    ce_pix = 1'b1;
    cyc(2);
    check("resume_ce", 32'({r, g, b}), 32'({6'h32, 6'h09, 6'h17}));

    // Read-back
    host_wr(2'd2, 8'd6);
    host_rd(2'd1);
    check("rb_r", 32'(io_do), m_rb_en ? 32'h20 : 32'h0);
    host_rd(2'd1);
    check("rb_g", 32'(io_do), m_rb_en ? 32'h21 : 32'h0);
    host_rd(2'd1);
    check("rb_b", 32'(io_do), m_rb_en ? 32'h22 : 32'h0);
    host_rd(2'd2);
    check("rb_idx", 32'(io_do), m_rb_en ? 32'd7 : 32'd0);
    cyc(2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
